cff_unit: RTL and testbench

CFF_UNIT -- requirements
Module: cff_unit

---
 rtl/cff_unit.sv | 131 +++++++++++++
 tb/tb_cff_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cff_unit.sv
// cff_unit: condition-code flag unit.
// Evaluates a 3-bit condition (taken from IR) over one or two BUS operands
// and registers the 1-bit result in flag.
//   Unary conds (0xx) resolve on the start edge.
//   Binary conds (1xx) latch A on start, then wait in WAIT_B for op_valid
//   carrying B. The wait aborts after TIMEOUT idle cycles.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   BUS[WIDTH-1:0]   operand A on start, operand B on op_valid
//   IR[31:0]         instruction register; cond = IR[COND_LSB+2:COND_LSB]
//   start            begin evaluation
//   op_valid         operand B present (only honoured in WAIT_B)
//   clear            synchronous cancel; flag forced to 0
//   flag, flag_n     registered result and its complement
//   busy             high while waiting for operand B
//   done             1-cycle pulse after the edge that loads flag
//   timeout          1-cycle pulse after the edge that aborts WAIT_B
module cff_unit #(
  parameter int WIDTH    = 32,
  parameter int COND_LSB = 19,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] BUS,
  input  logic [31:0]      IR,
  input  logic             start,
  input  logic             op_valid,
  input  logic             clear,
  output logic             flag,
  output logic             flag_n,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, WAIT_B = 1'b1} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [2:0]       cond_q, cond_d;
  logic [7:0]       cnt, cnt_d;
  logic             flag_d, done_d, to_d;
  logic [2:0]       cond;

  assign cond = IR[COND_LSB+2:COND_LSB];

  // Only the condition field of IR is consumed.
  logic unused_ir;
  assign unused_ir = ^IR;

  function automatic logic eval(input logic [2:0] c,
                                input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
    case (c)
      3'b000:  eval = (a == '0);
      3'b001:  eval = (a != '0);
      3'b010:  eval = ~a[WIDTH-1];
      3'b011:  eval = a[WIDTH-1];
      3'b100:  eval = (a == b);
      3'b101:  eval = (a != b);
      3'b110:  eval = ($signed(a) < $signed(b));
      default: eval = (a < b);
    endcase
  endfunction

  // Priority: clear > start > op_valid/timeout count.
  always_comb begin
    state_d = state;
    a_d     = a_q;
    cond_d  = cond_q;
    cnt_d   = cnt;
    flag_d  = flag;
    done_d  = 1'b0;
    to_d    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      flag_d  = 1'b0;
      cnt_d   = '0;
    end else if (start) begin
      if (cond[2]) begin
        state_d = WAIT_B;
        a_d     = BUS;
        cond_d  = cond;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        flag_d  = eval(cond, BUS, '0);
        done_d  = 1'b1;
      end
    end else if (state == WAIT_B) begin
      if (op_valid) begin
        state_d = IDLE;
        flag_d  = eval(cond_q, a_q, BUS);
        done_d  = 1'b1;
      end else if (cnt + 8'd1 == TO) begin
        state_d = IDLE;
        to_d    = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      cond_q  <= '0;
      cnt     <= '0;
      flag    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      a_q     <= a_d;
      cond_q  <= cond_d;
      cnt     <= cnt_d;
      flag    <= flag_d;
      done    <= done_d;
      timeout <= to_d;
    end
  end

  assign flag_n = ~flag;
  assign busy   = (state == WAIT_B);

endmodule

// File: tb/tb_cff_unit.sv
// tb_cff_unit: directed bench for cff_unit (WIDTH=32 and WIDTH=8 instances).
module tb_cff_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus, ir;
  logic        start, opv, clr;
  logic        flag, flag_n, busy, done, tmo;

  logic [7:0]  bus8;
  logic [31:0] ir8;
  logic        start8, opv8, clr8;
  logic        flag8, flag8_n, busy8, done8, tmo8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cff_unit #(.WIDTH(32), .COND_LSB(19), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .BUS(bus), .IR(ir), .start(start),
    .op_valid(opv), .clear(clr), .flag(flag), .flag_n(flag_n),
    .busy(busy), .done(done), .timeout(tmo)
  );

  cff_unit #(.WIDTH(8), .COND_LSB(19), .TIMEOUT(15)) dut8 (
    .clk(clk), .rst_n(rst_n), .BUS(bus8), .IR(ir8), .start(start8),
    .op_valid(opv8), .clear(clr8), .flag(flag8), .flag_n(flag8_n),
    .busy(busy8), .done(done8), .timeout(tmo8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input logic [2:0] c);
    return {10'd0, c, 19'd0};
  endfunction

  // Single-cycle start on the 32-bit unit, inputs released after the edge.
  task automatic go(input logic [2:0] c, input logic [31:0] v);
    ir = mk_ir(c); bus = v; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic go8(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                     input logic exp, input string tag);
    ir8 = mk_ir(c); bus8 = a; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({tag, "_busy"}, busy8, 1);
    bus8 = b; opv8 = 1'b1;
    tick();
    opv8 = 1'b0;
    chk({tag, "_flag"}, flag8, exp);
    chk({tag, "_done"}, done8, 1);
  endtask

  initial begin
    bus = '0; ir = '0; start = 0; opv = 0; clr = 0;
    bus8 = '0; ir8 = '0; start8 = 0; opv8 = 0; clr8 = 0;
    #12;
    chk("rst_flag", flag, 0);
    chk("rst_flag_n", flag_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", tmo, 0);
    rst_n = 1'b1;

    // unary conditions
    go(3'b000, 32'h0);
    chk("zero_flag", flag, 1);
    chk("zero_flag_n", flag_n, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_pulse", done, 0);
    go(3'b011, 32'h8000_0000);
    chk("neg_msb", flag, 1);
    go(3'b011, 32'h0000_0001);
    chk("neg_one", flag, 0);
    go(3'b010, 32'h0);
    chk("pos_zero", flag, 1);

    // signed vs unsigned less-than
    go(3'b110, 32'hFFFF_FFFF);
    chk("slt_busy1", busy, 1);
    chk("slt_nodone", done, 0);
    tick();
    chk("slt_busy2", busy, 1);
    bus = 32'h1; opv = 1'b1;
    tick();
    opv = 1'b0;
    chk("slt_flag", flag, 1);
    chk("slt_done", done, 1);
    chk("slt_busy_off", busy, 0);
    go(3'b111, 32'hFFFF_FFFF);
    tick();
    bus = 32'h1; opv = 1'b1;
    tick();
    opv = 1'b0;
    chk("ult_flag", flag, 0);
    chk("ult_done", done, 1);

    // timeout: set flag=1 first, it must survive the abort
    go(3'b000, 32'h0);
    go(3'b100, 32'h0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("to_wait_tmo", tmo, 0);
      chk("to_wait_busy", busy, 1);
    end
    tick();
    chk("to_pulse", tmo, 1);
    chk("to_busy", busy, 0);
    chk("to_flag_hold", flag, 1);
    chk("to_nodone", done, 0);
    bus = 32'h0; opv = 1'b1;
    tick();
    opv = 1'b0;
    chk("to_opv_ign_done", done, 0);
    chk("to_opv_ign_flag", flag, 1);
    chk("to_pulse_end", tmo, 0);

    // restart: start beats op_valid in WAIT_B
    go(3'b001, 32'h0);
    chk("nz_zero", flag, 0);
    go(3'b100, 32'h7);
    chk("rs_busy", busy, 1);
    ir = mk_ir(3'b001); bus = 32'h5; start = 1'b1; opv = 1'b1;
    tick();
    start = 1'b0; opv = 1'b0;
    chk("rs_flag", flag, 1);
    chk("rs_done", done, 1);
    chk("rs_idle", busy, 0);
    bus = 32'h7; opv = 1'b1;
    tick();
    opv = 1'b0;
    chk("rs_old_dropped", done, 0);
    chk("rs_flag_hold", flag, 1);

    // clear beats start
    ir = mk_ir(3'b000); bus = 32'h0; start = 1'b1; clr = 1'b1;
    tick();
    start = 1'b0; clr = 1'b0;
    chk("clr_flag", flag, 0);
    chk("clr_done", done, 0);

    // async reset mid-WAIT_B
    go(3'b000, 32'h0);
    go(3'b100, 32'h3);
    chk("ar_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flag", flag, 0);
    chk("ar_flag_n", flag_n, 1);
    chk("ar_busy_off", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_tmo", tmo, 0);
    #2 rst_n = 1'b1;
    ir = mk_ir(3'b000); bus = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ar_first_start", flag, 1);
    chk("ar_first_done", done, 1);
    chk("ar_first_tmo", tmo, 0);

    // 8-bit boundaries
    go8(3'b110, 8'h80, 8'h7F, 1'b1, "w8_slt");
    go8(3'b111, 8'h80, 8'h7F, 1'b0, "w8_ult");
    go8(3'b100, 8'h00, 8'h00, 1'b1, "w8_eq");
    go8(3'b101, 8'h00, 8'h00, 1'b0, "w8_ne");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // done and timeout are mutually exclusive
  always @(negedge clk) begin
    if (rst_n && done && tmo) begin
      bad++;
      $display("FAIL done_tmo_overlap got=1 exp=0");
    end
  end

endmodule
